// File: rtl/trig_sched_pkg.sv
// Shared types and widths for the Trigger Out round-robin scheduler.
package trig_sched_pkg;

    localparam int TRIG_W = 32;
    localparam int IDX_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past i_ptr and wraps,
// returning a one-hot grant and its encoded index.
module rr_arbiter
    import trig_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx
);

    logic          w_found;
    logic [PW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = PW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_pos]) begin
                w_found        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/trig_out_sched.sv
// Shares one Trigger Out ep_trigger bus among REQ_N requesters: one registered pulse
// per grant, then a low gap. TRIG_SCHED_HOLDOFF_EN adds a per-grant holdoff to the gap.
module trig_out_sched
    import trig_sched_pkg::*;
#(
    parameter  int REQ_N     = 4,
    parameter  int CNT_W     = 16,
    parameter  int HOLDOFF_W = 8,
    localparam int LG_W      = $clog2(REQ_N)
) (
    input  logic                   ep_clk,
    input  logic                   ti_reset,
    input  logic [REQ_N-1:0]       req_valid,
    input  logic [REQ_N*IDX_W-1:0] req_bit,
    output logic [REQ_N-1:0]       req_ready,
`ifdef TRIG_SCHED_HOLDOFF_EN
    input  logic [HOLDOFF_W-1:0]   holdoff,
`endif
    output logic [TRIG_W-1:0]      ep_trigger,
    output logic                   busy,
    output logic [LG_W-1:0]        last_grant,
    output logic [CNT_W-1:0]       pulse_count
);

    if (REQ_N < 2 || REQ_N > 8 || HOLDOFF_W < 1) begin : g_param_chk
        $error("trig_out_sched: REQ_N must be 2..8 and HOLDOFF_W at least 1");
    end

    state_t              r_state;
    logic [TRIG_W-1:0]   r_trig;
    logic [LG_W-1:0]     r_last;
    logic [CNT_W-1:0]    r_cnt;
`ifdef TRIG_SCHED_HOLDOFF_EN
    logic [HOLDOFF_W-1:0] r_hold;
`endif

    logic [REQ_N-1:0]    w_grant;
    logic [LG_W-1:0]     w_idx;
    logic [IDX_W-1:0]    w_sel_bit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    rr_arbiter #(.N(REQ_N)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    // Grants are only offered while idle and out of reset, so a transfer is |req_ready.
    assign req_ready = (r_state == IDLE && !ti_reset) ? w_grant : '0;

    always_comb begin
        w_sel_bit = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (w_grant[i]) begin
                w_sel_bit = req_bit[i*IDX_W +: IDX_W];
            end
        end
    end

    always_ff @(posedge ep_clk) begin
        if (ti_reset) begin
            r_state <= IDLE;
            r_trig  <= '0;
            r_last  <= LG_W'(REQ_N - 1);
            r_cnt   <= '0;
`ifdef TRIG_SCHED_HOLDOFF_EN
            r_hold  <= '0;
`endif
        end else begin
            r_trig <= '0;
            case (r_state)
                IDLE: begin
                    if (|req_ready) begin
                        r_state <= PULSE;
                        r_trig  <= TRIG_W'(1) << w_sel_bit;
                        r_last  <= w_idx;
                        r_cnt   <= sat_inc(r_cnt);
`ifdef TRIG_SCHED_HOLDOFF_EN
                        r_hold  <= holdoff;
`endif
                    end
                end
                PULSE: begin
                    r_state <= GAP;
                end
                GAP: begin
`ifdef TRIG_SCHED_HOLDOFF_EN
                    // Gap runs 1+holdoff cycles; the counter holds the extra cycles left.
                    if (r_hold == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
`else
                    r_state <= IDLE;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ep_trigger  = r_trig;
    assign busy        = (r_state != IDLE);
    assign last_grant  = r_last;
    assign pulse_count = r_cnt;

endmodule
